// File: rtl/udma_filter_pkg.sv
// Shared definitions for the udma filter tx fetch and rx output stages:
// addressing modes and element-size to address-increment mapping.
package udma_filter_pkg;

  typedef enum logic [1:0] {
    MODE_LINEAR   = 2'd0,
    MODE_SLIDING  = 2'd1,
    MODE_CIRCULAR = 2'd2,
    MODE_2D       = 2'd3
  } filter_mode_e;

  // Size code 3 is reserved and yields a stalled address (increment 0).
  function automatic logic [2:0] datasize_incr(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// Generic synchronous FIFO with occupancy output; head data is registered
// storage, so a pushed word becomes visible on the following cycle.
module io_generic_fifo #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_DEPTH     = 4,
  parameter int unsigned LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        clr_i,
  output logic [LOG_BUFFER_DEPTH:0]   elements_o,
  output logic [DATA_WIDTH-1:0]       data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  input  logic                        valid_i,
  input  logic [DATA_WIDTH-1:0]       data_i
);

  logic [DATA_WIDTH-1:0]         mem_q [BUFFER_DEPTH];
  logic [LOG_BUFFER_DEPTH-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LOG_BUFFER_DEPTH:0]     count_q;
  logic                          push, pop;

  function automatic logic [LOG_BUFFER_DEPTH-1:0] ptr_next(input logic [LOG_BUFFER_DEPTH-1:0] p);
    return (p == LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o    = (count_q != '0);
  assign data_o     = mem_q[rd_ptr_q];
  assign elements_o = count_q;
  assign push       = valid_i && (count_q < (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH));
  assign pop        = valid_o && ready_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/udma_filter_tx_datafetch.sv
// Filter tx fetch stage: walks the configured address pattern over L2, keeps
// reads within return-buffer credit and streams returned elements with sof/eof.
module udma_filter_tx_datafetch
  import udma_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned BUFFER_DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,

  output logic                      tx_ch_req_o,
  input  logic                      tx_ch_gnt_i,
  output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
  output logic [1:0]                tx_ch_datasize_o,
  input  logic                      tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
  output logic                      tx_ch_ready_o,

  input  logic                      cmd_start_i,
  output logic                      cmd_done_o,

  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,

  output logic [DATA_WIDTH-1:0]     stream_data_o,
  output logic                      stream_valid_o,
  input  logic                      stream_ready_i,
  output logic                      stream_sof_o,
  output logic                      stream_eof_o
);

  localparam int unsigned LOG_DEPTH = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW        = LOG_DEPTH + 2;

  typedef enum logic [1:0] {ST_IDLE, ST_RUNNING, ST_DRAIN} state_e;

  state_e                    state_q;
  filter_mode_e              mode_q;
  logic [1:0]                size_q;
  logic [L2_AWIDTH_NOAL-1:0] addr_q, base_q, start_q;
  logic [TRANS_SIZE-1:0]     w_q, l_q;
  logic [LOG_DEPTH:0]        outst_q;
  logic                      sof_pend_q, done_q;

  logic [LOG_DEPTH:0]        fifo_elems;
  logic                      fifo_valid;
  logic [DATA_WIDTH-1:0]     fifo_data;
  logic [L2_AWIDTH_NOAL-1:0] inc, stride;
  logic [CW-1:0]             credit_used;
  logic                      grant, row_end, last_req, stream_hs, last_elem;

  io_generic_fifo #(
    .DATA_WIDTH   (DATA_WIDTH),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) i_ret_fifo (
    .clk_i      (clk_i),
    .rstn_i     (resetn_i),
    .clr_i      (1'b0),
    .elements_o (fifo_elems),
    .data_o     (fifo_data),
    .valid_o    (fifo_valid),
    .ready_i    (stream_ready_i),
    .valid_i    (tx_ch_valid_i),
    .data_i     (tx_ch_data_i)
  );

  assign inc         = L2_AWIDTH_NOAL'(datasize_incr(size_q));
  assign stride      = L2_AWIDTH_NOAL'(cfg_len2_i);
  assign credit_used = CW'(outst_q) + CW'(fifo_elems);
  assign tx_ch_req_o = (state_q == ST_RUNNING) && (credit_used < CW'(BUFFER_DEPTH));
  assign grant       = tx_ch_req_o && tx_ch_gnt_i;
  assign row_end     = (w_q == cfg_len0_i);
  assign last_req    = row_end && ((mode_q == MODE_LINEAR) || (l_q == cfg_len1_i));
  assign stream_hs   = fifo_valid && stream_ready_i;
  // Once every request is granted, the last element is the sole one left.
  assign last_elem   = (state_q == ST_DRAIN) && (outst_q == '0) &&
                       (fifo_elems == (LOG_DEPTH + 1)'(1));

  assign tx_ch_addr_o     = addr_q;
  assign tx_ch_datasize_o = cfg_datasize_i;
  assign tx_ch_ready_o    = 1'b1;
  assign stream_data_o    = fifo_data;
  assign stream_valid_o   = fifo_valid;
  assign stream_sof_o     = fifo_valid && sof_pend_q;
  assign stream_eof_o     = fifo_valid && last_elem;
  assign cmd_done_o       = done_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_LINEAR;
      size_q     <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      start_q    <= '0;
      w_q        <= '0;
      l_q        <= '0;
      outst_q    <= '0;
      sof_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case ({grant, tx_ch_valid_i})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
      if (stream_hs) sof_pend_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (cmd_start_i) begin
            mode_q     <= filter_mode_e'(cfg_mode_i);
            size_q     <= cfg_datasize_i;
            start_q    <= cfg_start_addr_i;
            base_q     <= cfg_start_addr_i;
            addr_q     <= cfg_start_addr_i;
            w_q        <= '0;
            l_q        <= '0;
            sof_pend_q <= 1'b1;
            state_q    <= ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (grant) begin
            if (row_end) begin
              w_q <= '0;
              l_q <= l_q + 1'b1;
              case (mode_q)
                MODE_SLIDING: begin
                  base_q <= base_q + inc;
                  addr_q <= base_q + inc;
                end
                MODE_2D: begin
                  base_q <= base_q + stride;
                  addr_q <= base_q + stride;
                end
                default: addr_q <= start_q;
              endcase
              if (last_req) state_q <= ST_DRAIN;
            end else begin
              w_q    <= w_q + 1'b1;
              addr_q <= addr_q + inc;
            end
          end
        end
        ST_DRAIN: begin
          if (stream_hs && last_elem) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udma_filter_tx_datafetch.sv
// Scoreboard bench for the filter tx fetch stage: expected L2 addresses and
// stream elements are queued at job start and consumed as handshakes occur.
module tb_udma_filter_tx_datafetch;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        tx_ch_req_o, tx_ch_gnt_i;
  logic [14:0] tx_ch_addr_o;
  logic [1:0]  tx_ch_datasize_o;
  logic        tx_ch_valid_i;
  logic [31:0] tx_ch_data_i;
  logic        tx_ch_ready_o;
  logic        cmd_start_i, cmd_done_o;
  logic [14:0] cfg_start_addr_i;
  logic [1:0]  cfg_datasize_i, cfg_mode_i;
  logic [15:0] cfg_len0_i, cfg_len1_i, cfg_len2_i;
  logic [31:0] stream_data_o;
  logic        stream_valid_o, stream_ready_i, stream_sof_o, stream_eof_o;

  udma_filter_tx_datafetch #(
    .DATA_WIDTH     (32),
    .L2_AWIDTH_NOAL (15),
    .TRANS_SIZE     (16),
    .BUFFER_DEPTH   (4)
  ) dut (
    .clk_i            (clk_i),
    .resetn_i         (resetn_i),
    .tx_ch_req_o      (tx_ch_req_o),
    .tx_ch_gnt_i      (tx_ch_gnt_i),
    .tx_ch_addr_o     (tx_ch_addr_o),
    .tx_ch_datasize_o (tx_ch_datasize_o),
    .tx_ch_valid_i    (tx_ch_valid_i),
    .tx_ch_data_i     (tx_ch_data_i),
    .tx_ch_ready_o    (tx_ch_ready_o),
    .cmd_start_i      (cmd_start_i),
    .cmd_done_o       (cmd_done_o),
    .cfg_start_addr_i (cfg_start_addr_i),
    .cfg_datasize_i   (cfg_datasize_i),
    .cfg_mode_i       (cfg_mode_i),
    .cfg_len0_i       (cfg_len0_i),
    .cfg_len1_i       (cfg_len1_i),
    .cfg_len2_i       (cfg_len2_i),
    .stream_data_o    (stream_data_o),
    .stream_valid_o   (stream_valid_o),
    .stream_ready_i   (stream_ready_i),
    .stream_sof_o     (stream_sof_o),
    .stream_eof_o     (stream_eof_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } elem_t;

  logic [14:0] exp_addr_q[$];
  elem_t       exp_elem_q[$];
  logic [14:0] ret_q[$];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned eof_cyc = 0;
  int unsigned dones = 0;
  int unsigned grants = 0;
  int unsigned gnt_rand = 0;
  int unsigned rdy_mode = 0;  // 0: always ready, 1: random, 2: held low
  logic        held_valid = 1'b0;
  logic [31:0] held_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mkdata(input logic [14:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic check_reset_outputs();
    check("rst_req",   32'(tx_ch_req_o), 0);
    check("rst_valid", 32'(stream_valid_o), 0);
    check("rst_sof",   32'(stream_sof_o), 0);
    check("rst_eof",   32'(stream_eof_o), 0);
    check("rst_done",  32'(cmd_done_o), 0);
    check("rst_ready", 32'(tx_ch_ready_o), 1);
  endtask

  // One clock: drive inputs after negedge, sample 1ns later, score the
  // handshakes that the next rising edge will commit.
  task automatic step(input bit start);
    elem_t e;
    @(negedge clk_i);
    cmd_start_i    = start;
    tx_ch_gnt_i    = (gnt_rand != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    stream_ready_i = (rdy_mode == 2) ? 1'b0 :
                     (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (ret_q.size() > 0) begin
      tx_ch_valid_i = 1'b1;
      tx_ch_data_i  = mkdata(ret_q.pop_front());
    end else begin
      tx_ch_valid_i = 1'b0;
      tx_ch_data_i  = '0;
    end
    #1;
    cyc++;
    if (held_valid) begin
      check("hold_valid", 32'(stream_valid_o), 1);
      check("hold_data", stream_data_o, held_data);
    end
    held_valid = stream_valid_o && !stream_ready_i;
    held_data  = stream_data_o;
    if (tx_ch_req_o && tx_ch_gnt_i) begin
      grants++;
      if (exp_addr_q.size() == 0) check("extra_grant", 1, 0);
      else check("addr", 32'(tx_ch_addr_o), 32'(exp_addr_q.pop_front()));
      ret_q.push_back(tx_ch_addr_o);
    end
    if (stream_valid_o && stream_ready_i) begin
      if (exp_elem_q.size() == 0) check("extra_elem", 1, 0);
      else begin
        e = exp_elem_q.pop_front();
        check("data", stream_data_o, e.data);
        check("sof", 32'(stream_sof_o), 32'(e.sof));
        check("eof", 32'(stream_eof_o), 32'(e.eof));
        if (e.eof) eof_cyc = cyc;
      end
    end
    if (cmd_done_o) begin
      dones++;
      check("done_lat", cyc, eof_cyc + 1);
    end
  endtask

  task automatic load_job(input int mode, input int start, input int size,
                          input int len0, input int len1, input int len2);
    int inc, rows, total, idx, base;
    logic [14:0] a;
    cfg_mode_i       = 2'(mode);
    cfg_start_addr_i = 15'(start);
    cfg_datasize_i   = 2'(size);
    cfg_len0_i       = 16'(len0);
    cfg_len1_i       = 16'(len1);
    cfg_len2_i       = 16'(len2);
    inc   = (size == 0) ? 1 : (size == 1) ? 2 : (size == 2) ? 4 : 0;
    rows  = (mode == 0) ? 1 : len1 + 1;
    total = rows * (len0 + 1);
    idx   = 0;
    for (int l = 0; l < rows; l++) begin
      base = (mode == 1) ? start + l * inc :
             (mode == 3) ? start + l * len2 : start;
      for (int w = 0; w <= len0; w++) begin
        a = 15'(base + w * inc);
        exp_addr_q.push_back(a);
        exp_elem_q.push_back('{data: mkdata(a), sof: (idx == 0), eof: (idx == total - 1)});
        idx++;
      end
    end
    grants = 0;
    dones  = 0;
  endtask

  task automatic run_job(input string name, input int mode, input int start, input int size,
                         input int len0, input int len1, input int len2, input int hold);
    int unsigned k, saved_rdy, total;
    load_job(mode, start, size, len0, len1, len2);
    total = 32'(exp_elem_q.size());
    saved_rdy = rdy_mode;
    if (hold > 0) rdy_mode = 2;
    check({name, "_dsize"}, 32'(tx_ch_datasize_o), 32'(size));
    step(1'b1);
    k = 0;
    while (dones == 0 && k < 3000) begin
      step(k == 3 && total > 6);  // stray start while busy must be ignored
      k++;
      if (hold > 0 && k == 32'(hold)) begin
        check({name, "_hold_grants"}, grants, 4);
        check({name, "_hold_req"}, 32'(tx_ch_req_o), 0);
        rdy_mode = saved_rdy;
      end
    end
    if (dones == 0) check({name, "_timeout"}, 0, 1);
    for (int i = 0; i < 3; i++) step(1'b0);
    rdy_mode = saved_rdy;
    check({name, "_done_count"}, dones, 1);
    check({name, "_grants"}, grants, total);
    check({name, "_leftover"}, 32'(exp_addr_q.size() + exp_elem_q.size()), 0);
  endtask

  initial begin
    int unsigned k;
    resetn_i         = 1'b0;
    cmd_start_i      = 1'b0;
    tx_ch_gnt_i      = 1'b1;
    tx_ch_valid_i    = 1'b0;
    tx_ch_data_i     = '0;
    stream_ready_i   = 1'b1;
    cfg_start_addr_i = '0;
    cfg_datasize_i   = '0;
    cfg_mode_i       = '0;
    cfg_len0_i       = '0;
    cfg_len1_i       = '0;
    cfg_len2_i       = '0;
    repeat (3) @(negedge clk_i);
    #1;
    check_reset_outputs();
    @(negedge clk_i);
    resetn_i = 1'b1;

    run_job("linear",   0, 'h100, 2, 3, 0, 0, 0);
    run_job("sliding",  1, 'h000, 0, 1, 2, 0, 0);
    run_job("twod",     3, 'h040, 1, 1, 1, 'h20, 0);
    run_job("backpres", 0, 'h300, 2, 7, 0, 0, 20);
    run_job("circ1",    2, 'h7FFF, 0, 0, 0, 0, 0);
    run_job("wrap",     0, 'h7FFF, 0, 1, 0, 0, 0);
    run_job("inc0",     0, 'h055, 3, 2, 0, 0, 0);

    gnt_rand = 1;
    rdy_mode = 1;
    run_job("circ_rnd",  2, 'h7FFC, 1, 2, 2, 0, 0);
    run_job("slide_rnd", 1, 'h010, 1, 3, 3, 0, 0);
    run_job("twod_rnd",  3, 'h7FE0, 2, 2, 2, 'h30, 0);
    gnt_rand = 0;
    rdy_mode = 0;

    // Abandon a job after its second grant.
    load_job(0, 'h200, 2, 7, 0, 0);
    step(1'b1);
    k = 0;
    while (grants < 2 && k < 50) begin
      step(1'b0);
      k++;
    end
    check("rst_mid_grants", grants, 2);
    @(negedge clk_i);
    resetn_i      = 1'b0;
    cmd_start_i   = 1'b0;
    tx_ch_valid_i = 1'b0;
    #1;
    check_reset_outputs();
    ret_q.delete();
    exp_addr_q.delete();
    exp_elem_q.delete();
    held_valid = 1'b0;
    @(negedge clk_i);
    #1;
    check_reset_outputs();
    @(negedge clk_i);
    resetn_i = 1'b1;
    run_job("after_rst", 0, 'h200, 2, 7, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule
